// File: rtl/pcm_frame_sched_pkg.sv
// rtl/pcm_frame_sched_pkg.sv - shared constants, state encoding and helpers for the PCM frame scheduler
package pcm_frame_sched_pkg;

  localparam int ADDR_W         = 10;
  localparam int DEF_BANK_BYTES = 512;
  localparam int DEF_HDR_BYTES  = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_LO  = 3'd1,
    WR_HI  = 3'd2,
    CHK    = 3'd3,
    SEQ_LO = 3'd4,
    SEQ_HI = 3'd5,
    LAUNCH = 3'd6
  } state_t;

  // Overflow counter add that pins at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/pcm_frame_sched_if.sv
// rtl/pcm_frame_sched_if.sv - sample input, BRAM write port and Ethernet launch signals
interface pcm_frame_sched_if;
  import pcm_frame_sched_pkg::*;

  logic              pcm_valid;
  logic [15:0]       pcm_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              eth_busy;
  logic              eth_start;
  logic [ADDR_W-1:0] eth_base;
  logic [15:0]       seq;
  logic [7:0]        ovf_cnt;

  modport master (
    input  pcm_valid, pcm_data, eth_busy,
    output wr_en, wr_addr, wr_data, eth_start, eth_base, seq, ovf_cnt
  );

  modport slave (
    output pcm_valid, pcm_data, eth_busy,
    input  wr_en, wr_addr, wr_data, eth_start, eth_base, seq, ovf_cnt
  );

endinterface

// File: rtl/pcm_skid1.sv
// rtl/pcm_skid1.sv - one-deep pending sample register with drop flag
module pcm_skid1 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] head,
  output logic         drop
);

  // A push into a full slot is only lost when the slot is not drained the same cycle.
  assign drop = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      head <= '0;
    end else if (push && (pop || !full)) begin
      full <= 1'b1;
      head <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pcm_frame_sched.sv
// rtl/pcm_frame_sched.sv - packs PCM samples into ping-pong BRAM banks and launches Ethernet frames
module pcm_frame_sched
  import pcm_frame_sched_pkg::*;
#(
  parameter int BANK_BYTES = DEF_BANK_BYTES,
  parameter int HDR_BYTES  = DEF_HDR_BYTES
) (
  input logic              clk,
  input logic              rst_n,
  pcm_frame_sched_if.master bus
);

  localparam addr_t BANK_SZ = addr_t'(BANK_BYTES);
  localparam addr_t HDR_OFF = addr_t'(HDR_BYTES);

  state_t      state, state_nx;
  logic        bank, bank_nx;
  addr_t       ptr, ptr_nx;
  logic [15:0] seq_q, seq_nx;
  logic [15:0] sample, sample_nx;
  addr_t       eth_base_q, eth_base_nx;
  logic [7:0]  ovf_q;

  logic        wr_en;
  addr_t       wr_addr;
  logic [7:0]  wr_data;
  logic        eth_start;
  addr_t       eth_base;
  logic        frame_drop;

  logic        sk_push, sk_pop, sk_full, sk_drop;
  logic [15:0] sk_head;

  addr_t bank_base, bank_end, other_base;

  // For the upper bank the end address is 1024, which truncates to 0 in 10 bits;
  // ptr truncates the same way, so the equality test still holds.
  assign bank_base  = bank ? BANK_SZ : '0;
  assign bank_end   = bank_base + BANK_SZ;
  assign other_base = bank ? '0 : BANK_SZ;

  // A strobe goes straight into the sample latch only in IDLE with nothing pending.
  assign sk_push = bus.pcm_valid && !(state == IDLE && !sk_full);

  pcm_skid1 #(.W(16)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sk_push),
    .push_data (bus.pcm_data),
    .pop       (sk_pop),
    .full      (sk_full),
    .head      (sk_head),
    .drop      (sk_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank       <= 1'b0;
      ptr        <= HDR_OFF;
      seq_q      <= '0;
      sample     <= '0;
      eth_base_q <= '0;
      ovf_q      <= '0;
    end else begin
      state      <= state_nx;
      bank       <= bank_nx;
      ptr        <= ptr_nx;
      seq_q      <= seq_nx;
      sample     <= sample_nx;
      eth_base_q <= eth_base_nx;
      ovf_q      <= sat_add8(ovf_q, {1'b0, sk_drop} + {1'b0, frame_drop});
    end
  end

  always_comb begin
    state_nx    = state;
    bank_nx     = bank;
    ptr_nx      = ptr;
    seq_nx      = seq_q;
    sample_nx   = sample;
    eth_base_nx = eth_base_q;
    sk_pop      = 1'b0;
    frame_drop  = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    eth_start   = 1'b0;
    eth_base    = eth_base_q;

    unique case (state)
      IDLE: begin
        if (sk_full) begin
          sample_nx = sk_head;
          sk_pop    = 1'b1;
          state_nx  = WR_LO;
        end else if (bus.pcm_valid) begin
          sample_nx = bus.pcm_data;
          state_nx  = WR_LO;
        end
      end
      WR_LO: begin
        wr_en    = 1'b1;
        wr_addr  = ptr;
        wr_data  = sample[7:0];
        state_nx = WR_HI;
      end
      WR_HI: begin
        wr_en    = 1'b1;
        wr_addr  = ptr + addr_t'(1);
        wr_data  = sample[15:8];
        ptr_nx   = ptr + addr_t'(2);
        state_nx = CHK;
      end
      CHK: begin
        state_nx = (ptr == bank_end) ? SEQ_LO : IDLE;
      end
      SEQ_LO: begin
        wr_en    = 1'b1;
        wr_addr  = bank_base + HDR_OFF - addr_t'(2);
        wr_data  = seq_q[7:0];
        state_nx = SEQ_HI;
      end
      SEQ_HI: begin
        wr_en    = 1'b1;
        wr_addr  = bank_base + HDR_OFF - addr_t'(1);
        wr_data  = seq_q[15:8];
        state_nx = LAUNCH;
      end
      LAUNCH: begin
        if (!bus.eth_busy) begin
          eth_start   = 1'b1;
          eth_base    = bank_base;
          eth_base_nx = bank_base;
          bank_nx     = ~bank;
          seq_nx      = seq_q + 16'd1;
          ptr_nx      = other_base + HDR_OFF;
        end else begin
          // Transmitter still busy: drop this frame and refill the same bank.
          frame_drop = 1'b1;
          ptr_nx     = bank_base + HDR_OFF;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.eth_start = eth_start;
  assign bus.eth_base  = eth_base;
  assign bus.seq       = seq_q;
  assign bus.ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_pcm_frame_sched.sv
// tb/tb_pcm_frame_sched.sv - scoreboard bench for the PCM frame scheduler
module tb_pcm_frame_sched;
  import pcm_frame_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcm_frame_sched_if bus();

  pcm_frame_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int base; int seq; } ln_t;

  wr_t wq[$];
  ln_t lq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b1;

  int m_ptr, m_bank, m_seq, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every launch must match the head of its queue.
  always @(negedge clk) begin
    wr_t w;
    ln_t l;
    if (check_en && rst_n) begin
      if (bus.wr_en === 1'b1) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", bus.wr_addr, w.addr);
          chk("wr_data", bus.wr_data, w.data);
        end
      end
      if (bus.eth_start === 1'b1) begin
        if (lq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_eth_start: base %0d, expected no launch", bus.eth_base);
        end else begin
          l = lq.pop_front();
          chk("eth_base", bus.eth_base, l.base);
          chk("launch_seq", bus.seq, l.seq);
        end
      end
    end
  end

  task automatic model_reset();
    m_ptr = 16; m_bank = 0; m_seq = 0; m_ovf = 0;
  endtask

  task automatic model_push(input logic [15:0] d);
    int base;
    wq.push_back('{m_ptr, int'(d[7:0])});
    wq.push_back('{m_ptr + 1, int'(d[15:8])});
    m_ptr += 2;
    base = m_bank * 512;
    if (m_ptr == base + 512) begin
      wq.push_back('{base + 14, m_seq & 255});
      wq.push_back('{base + 15, (m_seq >> 8) & 255});
      if (bus.eth_busy === 1'b0) begin
        lq.push_back('{base, m_seq});
        m_bank ^= 1;
        m_seq = (m_seq + 1) & 16'hFFFF;
        m_ptr = m_bank * 512 + 16;
      end else begin
        m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
        m_ptr = base + 16;
      end
    end
  endtask

  task automatic send(input logic [15:0] d);
    model_push(d);
    @(posedge clk); #1;
    bus.pcm_valid = 1'b1;
    bus.pcm_data  = d;
    @(posedge clk); #1;
    bus.pcm_valid = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic send_n(input int n, input int tag);
    for (int i = 0; i < n; i++) send(16'((tag << 12) ^ (i * 16'h0107) ^ 16'h5A3C));
  endtask

  task automatic fill_bank();
    send_n((m_bank * 512 + 512 - m_ptr) / 2, m_ptr);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && (wq.size() != 0 || lq.size() != 0); i++) @(posedge clk);
    chk(name, wq.size() + lq.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"},     bus.wr_en, 0);
    chk({tag, "_wr_addr"},   bus.wr_addr, 0);
    chk({tag, "_wr_data"},   bus.wr_data, 0);
    chk({tag, "_eth_start"}, bus.eth_start, 0);
    chk({tag, "_eth_base"},  bus.eth_base, 0);
    chk({tag, "_seq"},       bus.seq, 0);
    chk({tag, "_ovf_cnt"},   bus.ovf_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pcm_valid = 1'b0;
    bus.pcm_data  = '0;
    bus.eth_busy  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // First sample: LO byte one cycle after the strobe, HI byte the next cycle
    model_push(16'h1234);
    @(posedge clk); #1;
    bus.pcm_valid = 1'b1;
    bus.pcm_data  = 16'h1234;
    @(posedge clk); #1;
    bus.pcm_valid = 1'b0;
    chk("lat_lo_en",   bus.wr_en, 1);
    chk("lat_lo_addr", bus.wr_addr, 16);
    chk("lat_lo_data", bus.wr_data, 8'h34);
    @(posedge clk); #1;
    chk("lat_hi_addr", bus.wr_addr, 17);
    chk("lat_hi_data", bus.wr_data, 8'h12);
    repeat (8) @(posedge clk);

    // Complete bank 0 with the transmitter idle; next sample lands at 528
    fill_bank();
    chk("seq_after_launch", bus.seq, 1);
    chk("eth_base_held", bus.eth_base, 0);
    send(16'hBEEF);
    drain("drain_frame0");

    // Fill bank 1 while busy: frame dropped, bank refilled from 528
    bus.eth_busy = 1'b1;
    fill_bank();
    bus.eth_busy = 1'b0;
    send(16'hC0DE);
    drain("drain_drop");
    chk("ovf_frame_drop", bus.ovf_cnt, 1);
    chk("seq_unchanged", bus.seq, 1);

    // Three back-to-back strobes: third is dropped
    model_push(16'h1111);
    model_push(16'h2222);
    m_ovf++;
    @(posedge clk); #1;
    bus.pcm_valid = 1'b1; bus.pcm_data = 16'h1111;
    @(posedge clk); #1;
    bus.pcm_data = 16'h2222;
    @(posedge clk); #1;
    bus.pcm_data = 16'h3333;
    @(posedge clk); #1;
    bus.pcm_valid = 1'b0;
    repeat (15) @(posedge clk);
    drain("drain_burst");
    chk("ovf_sample_drop", bus.ovf_cnt, m_ovf);

    // Reset mid-frame after 100 samples, then a full fresh frame
    send_n(100, 7);
    drain("drain_pre_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_n(248, 9);
    drain("drain_post_reset");
    chk("seq_post_reset", bus.seq, 1);

    // Flood with strobes: ovf_cnt must pin at 255
    check_en = 1'b0;
    bus.eth_busy = 1'b1;
    for (int i = 0; i < 420; i++) begin
      @(posedge clk); #1;
      bus.pcm_valid = 1'b1;
      bus.pcm_data  = 16'(i);
    end
    @(posedge clk); #1;
    bus.pcm_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("ovf_saturated", bus.ovf_cnt, 255);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus.pcm_valid = 1'b1;
      bus.pcm_data  = 16'(i);
    end
    @(posedge clk); #1;
    bus.pcm_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("ovf_still_saturated", bus.ovf_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_frame_sched.md
PCM_FRAME_SCHED -- requirements
Module: pcm_frame_sched

Interface
REQ-001 Parameter BANK_BYTES, default 512, bytes per ping-pong bank in the shared 1024-byte frame BRAM.
REQ-002 Parameter HDR_BYTES, default 16, header bytes at the start of each bank; payload follows.
REQ-003 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port pcm_valid, input, 1, one-cycle strobe: pcm_data holds a new signed sample.
REQ-006 Port pcm_data, input, 16, signed PCM sample.
REQ-007 Port wr_en, output, 1, BRAM write enable.
REQ-008 Port wr_addr, output, 10, BRAM write address.
REQ-009 Port wr_data, output, 8, BRAM write byte.
REQ-010 Port eth_busy, input, 1, Ethernet transmitter is sending a frame.
REQ-011 Port eth_start, output, 1, one-cycle pulse that starts a frame transmit.
REQ-012 Port eth_base, output, 10, base address of the bank to transmit; valid while eth_start=1 and held until the next eth_start.
REQ-013 Port seq, output, 16, sequence number of the next frame to launch.
REQ-014 Port ovf_cnt, output, 8, saturating count of dropped samples plus dropped frames.

Function
REQ-015 States IDLE, WR_LO, WR_HI, CHK, SEQ_LO, SEQ_HI, LAUNCH; one state per cycle except IDLE.
REQ-016 IDLE with a pending sample, or with pcm_valid=1 and none pending: latch the sample and go to WR_LO; a pending sample is served before the concurrent pcm_valid, which then becomes pending.
REQ-017 WR_LO: wr_en=1, wr_addr=ptr, wr_data=sample[7:0]; WR_HI: wr_en=1, wr_addr=ptr+1, wr_data=sample[15:8], ptr+=2.
REQ-018 CHK: if ptr == bank_base+BANK_BYTES go to SEQ_LO, else go to IDLE.
REQ-019 SEQ_LO writes seq[7:0] at bank_base+HDR_BYTES-2; SEQ_HI writes seq[15:8] at bank_base+HDR_BYTES-1.
REQ-020 LAUNCH, eth_busy=0: eth_start=1 for one cycle, eth_base=bank_base, bank toggles, seq+=1 (wraps at 16 bits), ptr=new bank_base+HDR_BYTES, then IDLE.
REQ-021 LAUNCH, eth_busy=1: frame dropped, no eth_start, bank and seq unchanged, ptr=bank_base+HDR_BYTES, ovf_cnt+=1, then IDLE.
REQ-022 Write latency: a sample strobed in IDLE appears on wr_en one cycle later (LO byte), then HI byte on the next cycle.
REQ-023 pcm_valid outside IDLE is held in a one-deep pending register; pcm_valid while pending is full drops the new sample and increments ovf_cnt.
REQ-024 ovf_cnt saturates at 255; simultaneous sample drop and frame drop add 2, saturating.
REQ-025 wr_en=0 in IDLE, CHK and LAUNCH; eth_start=0 in all states except LAUNCH.
REQ-026 The scheduler never writes into the non-active bank; address arithmetic stays in 10 bits and needs no wrap.

Reset
REQ-027 rst_n low: state=IDLE, bank=0, ptr=HDR_BYTES, seq=0, ovf_cnt=0, pending empty, wr_en=0, wr_addr=0, wr_data=0, eth_start=0, eth_base=0.
REQ-028 Reset mid-frame discards the partial frame; no eth_start is issued until a full new frame is collected.

Structure
REQ-029 A shared package holds BANK_BYTES, HDR_BYTES, the state encoding, and the BRAM address width (10).
REQ-030 One sub-module, pcm_skid1, implements the one-deep pending register with a drop flag.

Verification
REQ-031 Stimulus: reset, then pcm_data=16'h1234 strobed. Required: writes (16,8'h34) then (17,8'h12) on consecutive cycles.
REQ-032 Stimulus: 248 samples every 10 cycles with eth_busy=0. Required: seq bytes 00,00 written at 14,15; eth_start pulse with eth_base=0; next sample written at 528; seq=1.
REQ-033 Stimulus: fill a second frame with eth_busy=1 held. Required: no eth_start, ovf_cnt=1, the next sample rewrites address 528, seq unchanged.
REQ-034 Stimulus: three pcm_valid strobes on consecutive cycles. Required: first two written, third dropped, ovf_cnt+1.
REQ-035 Stimulus: rst_n asserted after 100 samples. Required: all outputs at reset values, the next sample is written at address 16, and eth_start fires only after 248 further samples.
REQ-036 Stimulus: 300 forced drops. Required: ovf_cnt stays at 255.
